digit_entry: RTL and testbench
==============================

# digit_entry

Button-driven decimal operand entry unit for the calculator datapath. It debounces the five Basys3 push buttons, lets the user build an operand one BCD digit at a time, and converts the committed digits to binary on confirm. It delivers operands A and B alternately to the arithmetic core and exports the in-progress BCD value to the seven-segment driver.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a button level change (0.5 ms at 100 MHz).
- `MAX_DIGITS`, default 4: maximum committed digits per operand (1..4).
- `CLK100MHZ`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `btnU`, `btnD`, `btnL`, `btnR`, `btnC`  in  1 each  raw asynchronous button levels.
- `entry_en`  in  1  when low, accepted button events are discarded (debouncers keep running).
- `clear`  in  1  single-cycle; discards the entry and returns to operand A.
- `operand`  out  14  binary operand value, held between emissions.
- `operand_valid`  out  1  one-cycle strobe; `operand` is valid.
- `operand_sel`  out  1  0 = operand A, 1 = operand B; qualifies `operand_valid`.
- `disp_bcd`  out  16  committed digits, nibble 0 = least significant, unused nibbles 0.
- `cur_digit`  out  4  digit being edited (0..9).
- `digit_count`  out  3  number of committed digits.
- `busy`  out  1  high in CONV and EMIT.

## Operation
- Per button: 2-FF synchronizer, then a stable counter. When the synced level differs from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level flips. A rising edge of the debounced level produces a one-cycle event. Any bounce restarts the count.
- Event priority when several fire in one cycle: C > L > R > U > D. Only the winner is processed; the others are dropped.
- FSM states:
  - EDIT:
    - U: `cur_digit` +1, 9 wraps to 0.
    - D: `cur_digit` -1, 0 wraps to 9.
    - L (commit): if `digit_count` < `MAX_DIGITS`, shift `disp_bcd` left one nibble, insert `cur_digit` in nibble 0, increment the count, set `cur_digit` to 0. At full it is a no-op.
    - R: see Configuration.
    - C: go to CONV. The uncommitted `cur_digit` is ignored.
  - CONV: acc = acc*10 + next digit, most significant committed digit first, one digit per cycle. acc is 14 bits; 9999 is the maximum and fits. After the last digit, go to EMIT. With `digit_count` = 0, go directly to EMIT with acc = 0.
  - EMIT:
    - `operand` <= acc and pulse `operand_valid` with the current `operand_sel`.
    - Then toggle `operand_sel`, clear `disp_bcd`, `cur_digit` and `digit_count`, and return to EDIT.
- Events arriving in CONV or EMIT are discarded.
- `clear` has priority over every event in any state: behaves as reset for all state except the debouncers.
- Reset values: `operand` = 0, `operand_valid` = 0, `operand_sel` = 0, `disp_bcd` = 0, `cur_digit` = 0, `digit_count` = 0, `busy` = 0, FSM = EDIT, debounced levels = 0, counters = 0.
- Reset mid-CONV aborts the conversion and produces no strobe.

## Timing
- Button press to event: 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- Events U, D, L and R update the outputs on the cycle after the event.
- C event to `operand_valid`: `digit_count` + 2 cycles (1 cycle to enter CONV, `digit_count` CONV cycles, then EMIT). For 0 digits: 2 cycles.
- Within the EMIT cycle:
  - `operand` and `operand_valid` are registered together.
  - `operand_sel` toggles on the following cycle, so the strobe is always paired with the pre-toggle select.
- A release or press shorter than `DEBOUNCE_CYCLES` has no effect.
- Holding a button produces exactly one event; there is no auto-repeat.

## Configuration
- `DIGIT_ENTRY_BACKSPACE_EN` defined:
  - R in EDIT with `digit_count` > 0 shifts `disp_bcd` right one nibble (zero-fill at top), decrements the count, and loads the removed digit into `cur_digit`.
  - R with count 0 is a no-op.
- Not defined: R events are ignored. The btnR debouncer is still instantiated, but its event is unused.

## Test plan
Use `DEBOUNCE_CYCLES` = 8 for all scenarios.
- 9×U, L, repeated 3×, then C: `disp_bcd` = 16'h0999 before C. Then `operand_valid` pulses with `operand` = 999 and `operand_sel` = 0, 5 cycles after the C event. Afterwards `digit_count` = 0.
- Repeat the same entry: `operand` = 999 with `operand_sel` = 1. After a following C with no digits, `operand` = 0 with `operand_sel` = 0.
- Wrap and glitch:
  - 11×U gives `cur_digit` = 1; D, D gives 9.
  - A 5-cycle btnU pulse leaves `cur_digit` unchanged.
  - A bouncing press (3 on / 2 off / 10 on) yields one increment.
- Full and priority:
  - 5×(U, L) gives `digit_count` = 4 and `disp_bcd` = 16'h1111.
  - C and U asserted in the same cycle: only C is processed; `operand` = 1111.
- Backspace (macro defined): enter 1, 2, 3 committed, then R gives `disp_bcd` = 16'h0012 and `cur_digit` = 3. Without the macro, `disp_bcd` stays 16'h0123.
- Reset and clear:
  - `reset` asserted during CONV gives no `operand_valid` and all outputs at their reset values.
  - `clear` after operand A gives `operand_sel` = 0.
  - With `entry_en` = 0, U presses are ignored.

Source files
------------

// File: rtl/digit_entry.sv
// digit_entry: debounced push-button decimal operand entry for the calculator.
// Buttons build a BCD operand digit by digit; confirm (btnC) converts the
// committed digits to binary and emits operand A and B alternately.
// Build option: define DIGIT_ENTRY_BACKSPACE_EN to make btnR delete the most
// recently committed digit (without it, btnR events are ignored).
module digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned MAX_DIGITS      = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnC,
    input  logic        entry_en,
    input  logic        clear,
    output logic [13:0] operand,
    output logic        operand_valid,
    output logic        operand_sel,
    output logic [15:0] disp_bcd,
    output logic [3:0]  cur_digit,
    output logic [2:0]  digit_count,
    output logic        busy
);

    // Button bit positions inside the packed button vectors.
    localparam int unsigned B_U = 0;
    localparam int unsigned B_D = 1;
    localparam int unsigned B_L = 2;
    localparam int unsigned B_R = 3;
    localparam int unsigned B_C = 4;

    // The stable counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       COUNT_MAX = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        EDIT,
        CONV,
        EMIT
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_U,
        EV_D,
        EV_L,
        EV_R,
        EV_C
    } event_t;

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    logic [4:0]       raw;
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       deb;
    logic [4:0]       deb_prev;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       events;

    assign raw = {btnC, btnR, btnL, btnD, btnU};

    // Synchronize each button and flip its debounced level after a full run of stable cycles.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= ~deb[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign events = deb & ~deb_prev;

    // ------------------------------------------------------------------
    // Event arbitration
    // ------------------------------------------------------------------
    event_t winner;

    // Pick a single event per cycle: C > L > R > U > D. R always takes part
    // in arbitration, so a simultaneous R suppresses U/D even when it has no action.
    always_comb begin
        winner = EV_NONE;
        if (events[B_C]) begin
            winner = EV_C;
        end else if (events[B_L]) begin
            winner = EV_L;
        end else if (events[B_R]) begin
            winner = EV_R;
        end else if (events[B_U]) begin
            winner = EV_U;
        end else if (events[B_D]) begin
            winner = EV_D;
        end
    end

    // ------------------------------------------------------------------
    // Entry / conversion FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_n;
    logic [13:0] acc;
    logic [13:0] acc_n;
    logic [2:0]  idx;
    logic [2:0]  idx_n;
    logic [13:0] operand_n;
    logic        valid_n;
    logic        sel_n;
    logic [15:0] disp_n;
    logic [3:0]  cur_n;
    logic [2:0]  count_n;
    logic [15:0] conv_src;
    logic [3:0]  conv_digit;

    // Digit idx-1 counts from the least significant nibble, so walking idx
    // down from digit_count feeds the most significant committed digit first.
    assign conv_src   = disp_bcd >> {idx - 3'd1, 2'b00};
    assign conv_digit = conv_src[3:0];

    // State and datapath registers; clear acts like reset except for the debouncers.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || clear) begin
            state         <= EDIT;
            acc           <= '0;
            idx           <= '0;
            operand       <= '0;
            operand_valid <= 1'b0;
            operand_sel   <= 1'b0;
            disp_bcd      <= '0;
            cur_digit     <= '0;
            digit_count   <= '0;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            idx           <= idx_n;
            operand       <= operand_n;
            operand_valid <= valid_n;
            operand_sel   <= sel_n;
            disp_bcd      <= disp_n;
            cur_digit     <= cur_n;
            digit_count   <= count_n;
        end
    end

    // Next-state and datapath update for edit, conversion and emission.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        idx_n     = idx;
        operand_n = operand;
        valid_n   = 1'b0;
        // The select flips in the cycle the strobe is visible, so the strobe
        // always carries the pre-toggle select.
        sel_n     = operand_sel ^ operand_valid;
        disp_n    = disp_bcd;
        cur_n     = cur_digit;
        count_n   = digit_count;

        unique case (state)
            EDIT: begin
                if (entry_en) begin
                    unique case (winner)
                        EV_U: begin
                            cur_n = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
                        end
                        EV_D: begin
                            cur_n = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                        end
                        EV_L: begin
                            if (digit_count < COUNT_MAX) begin
                                disp_n  = {disp_bcd[11:0], cur_digit};
                                count_n = digit_count + 3'd1;
                                cur_n   = 4'd0;
                            end
                        end
                        EV_R: begin
`ifdef DIGIT_ENTRY_BACKSPACE_EN
                            if (digit_count != 3'd0) begin
                                disp_n  = {4'h0, disp_bcd[15:4]};
                                count_n = digit_count - 3'd1;
                                cur_n   = disp_bcd[3:0];
                            end
`endif
                        end
                        EV_C: begin
                            acc_n   = '0;
                            idx_n   = digit_count;
                            state_n = (digit_count == 3'd0) ? EMIT : CONV;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            CONV: begin
                acc_n = (acc << 3) + (acc << 1) + {10'd0, conv_digit};
                idx_n = idx - 3'd1;
                if (idx == 3'd1) begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                operand_n = acc;
                valid_n   = 1'b1;
                disp_n    = '0;
                cur_n     = 4'd0;
                count_n   = 3'd0;
                state_n   = EDIT;
            end
            default: begin
                state_n = EDIT;
            end
        endcase
    end

    assign busy = (state != EDIT);

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: directed plus randomized button sequences for digit_entry,
// checked against a digit-list model of the operand being entered.
module tb_digit_entry;

    localparam int unsigned DEB  = 8;
    localparam int unsigned MAXD = 4;
    localparam int          HOLD = DEB + 6;
    localparam int          BU = 0, BD = 1, BL = 2, BR = 3, BC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn;
    logic        entry_en;
    logic        clear;
    logic [13:0] operand;
    logic        operand_valid;
    logic        operand_sel;
    logic [15:0] disp_bcd;
    logic [3:0]  cur_digit;
    logic [2:0]  digit_count;
    logic        busy;

    always #5 clk = ~clk;

    digit_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DIGITS     (MAXD)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .btnU         (btn[BU]),
        .btnD         (btn[BD]),
        .btnL         (btn[BL]),
        .btnR         (btn[BR]),
        .btnC         (btn[BC]),
        .entry_en     (entry_en),
        .clear        (clear),
        .operand      (operand),
        .operand_valid(operand_valid),
        .operand_sel  (operand_sel),
        .disp_bcd     (disp_bcd),
        .cur_digit    (cur_digit),
        .digit_count  (digit_count),
        .busy         (busy)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: committed digits, most significant first; digit being edited; next select.
    int digits[$];
    int cur_m = 0;
    bit sel_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int m_disp();
        int r = 0;
        foreach (digits[i]) r = r * 16 + digits[i];
        return r;
    endfunction

    function automatic int m_value();
        int r = 0;
        foreach (digits[i]) r = r * 10 + digits[i];
        return r;
    endfunction

    function automatic void m_reset();
        digits.delete();
        cur_m = 0;
        sel_m = 1'b0;
    endfunction

    function automatic void m_apply(input int b);
        if (!entry_en) return;
        case (b)
            BU: cur_m = (cur_m + 1) % 10;
            BD: cur_m = (cur_m + 9) % 10;
            BL: if (digits.size() < MAXD) begin
                    digits.push_back(cur_m);
                    cur_m = 0;
                end
`ifdef DIGIT_ENTRY_BACKSPACE_EN
            BR: if (digits.size() > 0) cur_m = digits.pop_back();
`endif
            default: ;
        endcase
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_cur"},   cur_digit, cur_m);
        chk({tag, "_count"}, digit_count, digits.size());
        chk({tag, "_disp"},  disp_bcd, m_disp());
        chk({tag, "_sel"},   operand_sel, sel_m);
        chk({tag, "_busy"},  busy, 0);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick(HOLD);
        btn[b] = 1'b0;
        tick(HOLD);
        m_apply(b);
    endtask

    task automatic press_chk(input int b, input string tag);
        press(b);
        check_state(tag);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        m_reset();
    endtask

    // Press C (optionally together with U) and check the strobe timing and contents.
    task automatic confirm(input string tag, input bit with_u);
        int exp_v = m_value();
        int n     = digits.size();
        int t;
        bit nsel  = !sel_m;
        btn[BC] = 1'b1;
        if (with_u) btn[BU] = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 4 * DEB) begin
            tick(1);
            t++;
        end
        chk({tag, "_busy"}, busy, 1);
        t = 0;
        while (operand_valid !== 1'b1 && t < 10) begin
            tick(1);
            t++;
        end
        chk({tag, "_lat"},   t, n + 1);
        chk({tag, "_valid"}, operand_valid, 1);
        chk({tag, "_op"},    operand, exp_v);
        chk({tag, "_sel"},   operand_sel, sel_m);
        tick(1);
        chk({tag, "_pulse"},  operand_valid, 0);
        chk({tag, "_seltog"}, operand_sel, nsel);
        chk({tag, "_hold"},   operand, exp_v);
        btn[BC] = 1'b0;
        btn[BU] = 1'b0;
        tick(HOLD);
        digits.delete();
        cur_m = 0;
        sel_m = nsel;
        check_state({tag, "_after"});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op"},    operand, 0);
        chk({tag, "_valid"}, operand_valid, 0);
        chk({tag, "_sel"},   operand_sel, 0);
        chk({tag, "_disp"},  disp_bcd, 0);
        chk({tag, "_cur"},   cur_digit, 0);
        chk({tag, "_count"}, digit_count, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int seen;
        int b;
        int np;

        reset    = 1'b1;
        btn      = '0;
        entry_en = 1'b1;
        clear    = 1'b0;
        tick(3);
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Three 9s, confirm as operand A, then again as operand B.
        for (int k = 0; k < 3; k++) begin
            repeat (9) press(BU);
            press_chk(BL, "nine");
        end
        chk("plan_disp", disp_bcd, 16'h0999);
        confirm("opA", 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (9) press(BU);
            press(BL);
        end
        check_state("nines2");
        confirm("opB", 1'b0);
        confirm("empty", 1'b0);

        // Debounce latency on a single U press: bounded window around DEB + 3.
        btn[BU] = 1'b1;
        t = 0;
        while (cur_digit === 4'(cur_m) && t < 4 * DEB) begin
            tick(1);
            t++;
        end
        chk("deb_lat_min", (t >= DEB + 2), 1);
        chk("deb_lat_max", (t <= DEB + 5), 1);
        tick(HOLD);
        btn[BU] = 1'b0;
        tick(HOLD);
        m_apply(BU);
        check_state("held_once");

        // Wrap: 11 total U gives 1; D, D gives 9.
        repeat (10) press(BU);
        chk("wrap_up", cur_digit, 1);
        press(BD);
        press(BD);
        chk("wrap_dn", cur_digit, 9);

        // Short glitch does nothing; bouncing press counts once.
        btn[BU] = 1'b1; tick(5); btn[BU] = 1'b0; tick(HOLD);
        check_state("glitch");
        btn[BU] = 1'b1; tick(3);
        btn[BU] = 1'b0; tick(2);
        btn[BU] = 1'b1; tick(10);
        btn[BU] = 1'b0; tick(HOLD);
        m_apply(BU);
        check_state("bounce");

        // Full entry and priority C over U.
        clear_pulse();
        check_state("clr0");
        repeat (5) begin
            press(BU);
            press(BL);
        end
        chk("full_count", digit_count, 4);
        chk("full_disp", disp_bcd, 16'h1111);
        confirm("prio", 1'b1);

        // Backspace behaviour on 1, 2, 3.
        press(BU); press(BL);
        repeat (2) press(BU); press(BL);
        repeat (3) press(BU); press(BL);
        chk("bs_pre", disp_bcd, 16'h0123);
        press(BR);
`ifdef DIGIT_ENTRY_BACKSPACE_EN
        chk("bs_disp", disp_bcd, 16'h0012);
        chk("bs_cur", cur_digit, 3);
`else
        chk("bs_disp", disp_bcd, 16'h0123);
        chk("bs_cur", cur_digit, 0);
`endif
        check_state("bs");
        confirm("bs_conf", 1'b0);

        // Reset in the middle of a conversion.
        repeat (4) begin
            press(BU);
            press(BL);
        end
        btn[BC] = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 4 * DEB) begin
            tick(1);
            t++;
        end
        chk("rc_busy", busy, 1);
        reset   = 1'b1;
        btn[BC] = 1'b0;
        tick(1);
        reset = 1'b0;
        chk_reset_outputs("rc");
        seen = 0;
        repeat (2 * HOLD) begin
            tick(1);
            if (operand_valid === 1'b1) seen++;
        end
        chk("rc_nostrobe", seen, 0);
        m_reset();
        check_state("rc_after");

        // Clear after operand A returns select to A.
        repeat (5) press(BU);
        press(BL);
        confirm("clrA", 1'b0);
        chk("clrA_sel1", operand_sel, 1);
        clear_pulse();
        check_state("clrA_clr");

        // Presses with entry disabled are discarded.
        entry_en = 1'b0;
        repeat (3) press(BU);
        press(BL);
        check_state("en_off");
        entry_en = 1'b1;

        // Randomized entry sessions.
        for (int op = 0; op < 6; op++) begin
            np = $urandom_range(0, 10);
            for (int p = 0; p < np; p++) begin
                t = $urandom_range(0, 9);
                b = (t < 4) ? BU : (t < 6) ? BD : (t < 9) ? BL : BR;
                entry_en = ($urandom_range(0, 7) != 0);
                press_chk(b, "rnd");
            end
            entry_en = 1'b1;
            confirm("rnd_conf", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
